blwl_bank_programmer: RTL and testbench

- Drives the memory-bank configuration protocol that tiles pass through on bl_in/bl_out and wl_in/wl_out; sits at the fabric edge and feeds the first tile's bl_in/wl_in.
- Accepts a bitstream as DATA_WIDTH-bit words on a valid/ready stream and assembles one BL row at a time.
- For each row, pulses exactly one word line so the addressed row of configuration cells latches the BL pattern.
- Walks WL rows 0..WL_WIDTH-1 once per session, then reports done.

---
 rtl/blwl_bank_programmer.sv | 169 ++++++++++++++++
 tb/tb_blwl_bank_programmer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/blwl_bank_programmer.sv
// Bank programmer: assembles BL rows from a word stream and pulses one WL per row.
// Optional parity checking with abort is enabled by defining BLWL_PARITY_CHECK_EN.
module blwl_bank_programmer #(
    parameter int unsigned BL_WIDTH        = 40,
    parameter int unsigned WL_WIDTH        = 4,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned WL_PULSE_CYCLES = 2
) (
    input  logic                  prog_clk,
    input  logic                  pReset_n,
    input  logic                  cfg_start,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    input  logic                  cfg_parity,
    output logic                  cfg_ready,
    output logic [BL_WIDTH-1:0]   bl,
    output logic [WL_WIDTH-1:0]   wl,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned Wpr    = BL_WIDTH / DATA_WIDTH;
    localparam int unsigned WordW  = (Wpr > 1) ? $clog2(Wpr) : 1;
    localparam int unsigned RowW   = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int unsigned PulseW = (WL_PULSE_CYCLES > 1) ? $clog2(WL_PULSE_CYCLES) : 1;

    localparam logic [WordW-1:0]  LastWord  = WordW'(Wpr - 1);
    localparam logic [RowW-1:0]   LastRow   = RowW'(WL_WIDTH - 1);
    localparam logic [PulseW-1:0] LastPulse = PulseW'(WL_PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSetup,
        StPulse,
        StHold
    } state_e;

    state_e              state_q, state_d;
    logic [RowW-1:0]     row_q, row_d;
    logic [WordW-1:0]    word_q, word_d;
    logic [PulseW-1:0]   pulse_q, pulse_d;
    logic [BL_WIDTH-1:0] bl_q, bl_d;
    logic [WL_WIDTH-1:0] wl_q, wl_d;
    logic                done_q, done_d;

`ifdef BLWL_PARITY_CHECK_EN
    logic err_q, err_d;
    logic parity_bad;

    assign parity_bad = ^{cfg_data, cfg_parity};
`else
    logic unused_parity;

    assign unused_parity = cfg_parity;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        word_d  = word_q;
        pulse_d = pulse_q;
        bl_d    = bl_q;
        done_d  = 1'b0;
`ifdef BLWL_PARITY_CHECK_EN
        err_d   = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse must not chain a new session.
                if (cfg_start && !done_q) begin
                    row_d   = '0;
                    word_d  = '0;
`ifdef BLWL_PARITY_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (cfg_valid) begin
`ifdef BLWL_PARITY_CHECK_EN
                    if (parity_bad) begin
                        err_d   = 1'b1;
                        word_d  = '0;
                        state_d = StIdle;
                    end else
`endif
                    begin
                        bl_d[word_q*DATA_WIDTH +: DATA_WIDTH] = cfg_data;
                        if (word_q == LastWord) begin
                            word_d  = '0;
                            state_d = StSetup;
                        end else begin
                            word_d = word_q + WordW'(1);
                        end
                    end
                end
            end
            StSetup: begin
                pulse_d = '0;
                state_d = StPulse;
            end
            StPulse: begin
                if (pulse_q == LastPulse) begin
                    state_d = StHold;
                end else begin
                    pulse_d = pulse_q + PulseW'(1);
                end
            end
            StHold: begin
                if (row_q == LastRow) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    row_d   = row_q + RowW'(1);
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered word line: asserted only for cycles spent in PULSE.
        wl_d = (state_d == StPulse) ? (WL_WIDTH'(1) << row_q) : '0;
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            word_q  <= '0;
            pulse_q <= '0;
            bl_q    <= '0;
            wl_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            word_q  <= word_d;
            pulse_q <= pulse_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            done_q  <= done_d;
        end
    end

`ifdef BLWL_PARITY_CHECK_EN
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cfg_ready = (state_q == StLoad);
    assign busy      = (state_q != StIdle);
    assign bl        = bl_q;
    assign wl        = wl_q;
    assign done      = done_q;

endmodule

// File: tb/tb_blwl_bank_programmer.sv
// Directed bench for blwl_bank_programmer: full sessions, stall gap, mid-pulse reset,
// ignored starts and parity handling, plus per-cycle WL/BL invariant checks.
module tb_blwl_bank_programmer;

    localparam int BW  = 40;
    localparam int WW  = 4;
    localparam int DW  = 8;
    localparam int PC  = 2;
    localparam int WPR = 5;

    logic          prog_clk   = 1'b0;
    logic          pReset_n   = 1'b0;
    logic          cfg_start  = 1'b0;
    logic [DW-1:0] cfg_data   = '0;
    logic          cfg_valid  = 1'b0;
    logic          cfg_parity = 1'b0;
    logic          cfg_ready;
    logic [BW-1:0] bl;
    logic [WW-1:0] wl;
    logic          busy;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    blwl_bank_programmer #(
        .BL_WIDTH       (BW),
        .WL_WIDTH       (WW),
        .DATA_WIDTH     (DW),
        .WL_PULSE_CYCLES(PC)
    ) dut (
        .prog_clk  (prog_clk),
        .pReset_n  (pReset_n),
        .cfg_start (cfg_start),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_parity(cfg_parity),
        .cfg_ready (cfg_ready),
        .bl        (bl),
        .wl        (wl),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    // Invariants sampled mid-cycle on every cycle.
    logic [BW-1:0] bl_prev = '0;
    always @(negedge prog_clk) begin
        if (pReset_n) begin
            chk("wl_onehot0", 64'($onehot0(wl)), 64'd1);
            if (wl != '0) begin
                chk("bl_frozen_under_wl", 64'(bl), 64'(bl_prev));
                chk("wl_only_when_busy", 64'(busy), 64'd1);
            end
        end
        bl_prev <= bl;
    end

    task automatic session(input int gap_k, input int gap_len, input int abort_row,
                           input int bad_word, input int poke_busy);
        logic [BW-1:0] exp_bl;
        int t0;
        int w;
        exp_bl    = '0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        t0 = cyc;
        chk("busy_rise", 64'(busy), 64'd1);
        chk("ready_in_load", 64'(cfg_ready), 64'd1);
        chk("err_cleared_on_start", 64'(err), 64'd0);
        for (int r = 0; r < WW; r++) begin
            for (int k = 0; k < WPR; k++) begin
                w = r * WPR + k;
                if (r == 0 && k == gap_k) begin
                    cfg_valid = 1'b0;
                    for (int g = 0; g < gap_len; g++) begin
                        step();
                        chk("gap_ready", 64'(cfg_ready), 64'd1);
                        chk("gap_wl", 64'(wl), 64'd0);
                    end
                end
                cfg_data   = DW'(w);
                cfg_parity = (^cfg_data) ^ (w == bad_word);
                cfg_valid  = 1'b1;
                if (poke_busy != 0 && r == 1 && k == 0) cfg_start = 1'b1;
                step();
                cfg_start = 1'b0;
                exp_bl[k*DW +: DW] = DW'(w);
                if (w == bad_word) begin
`ifdef BLWL_PARITY_CHECK_EN
                    cfg_valid = 1'b0;
                    chk("parity_abort_busy", 64'(busy), 64'd0);
                    chk("parity_err", 64'(err), 64'd1);
                    for (int i = 0; i < 12; i++) begin
                        step();
                        chk("parity_no_wl", 64'(wl), 64'd0);
                        chk("parity_no_done", 64'(done), 64'd0);
                        chk("parity_err_sticky", 64'(err), 64'd1);
                    end
                    return;
`else
                    chk("parity_ignored", 64'(err), 64'd0);
`endif
                end
            end
            cfg_valid = 1'b0;
            chk("setup_wl", 64'(wl), 64'd0);
            chk("setup_ready", 64'(cfg_ready), 64'd0);
            chk("setup_bl", 64'(bl), 64'(exp_bl));
            if (r == 0) chk("row0_bl", 64'(bl), 64'h0403020100);
            for (int p = 0; p < PC; p++) begin
                step();
                chk("pulse_wl", 64'(wl), 64'd1 << r);
                chk("pulse_bl", 64'(bl), 64'(exp_bl));
                chk("pulse_ready", 64'(cfg_ready), 64'd0);
                if (r == abort_row && p == 0) begin
                    #2 pReset_n = 1'b0;
                    #1;
                    chk("async_rst_wl", 64'(wl), 64'd0);
                    chk("async_rst_bl", 64'(bl), 64'd0);
                    chk("async_rst_busy", 64'(busy), 64'd0);
                    chk("async_rst_ready", 64'(cfg_ready), 64'd0);
                    return;
                end
            end
            step();
            chk("hold_wl", 64'(wl), 64'd0);
            chk("hold_bl", 64'(bl), 64'(exp_bl));
            chk("hold_done", 64'(done), 64'd0);
            if (r < WW - 1) begin
                step();
                chk("next_row_load", 64'(cfg_ready), 64'd1);
            end
        end
        step();
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_cycle", 64'(cyc - t0), 64'(36 + gap_len));
        chk("busy_fall", 64'(busy), 64'd0);
        chk("bl_kept_after", 64'(bl), 64'(exp_bl));
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("start_on_done_ignored", 64'(busy), 64'd0);
        step();
        chk("still_idle", 64'(busy), 64'd0);
        chk("idle_ready", 64'(cfg_ready), 64'd0);
    endtask

    initial begin
        #12;
        chk("rst_bl", 64'(bl), 64'd0);
        chk("rst_wl", 64'(wl), 64'd0);
        chk("rst_ready", 64'(cfg_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        pReset_n = 1'b1;
        step();
        step();
        chk("idle_no_start", 64'(busy), 64'd0);

        session(-1, 0, -1, -1, 0);
        session(3, 3, -1, -1, 1);
        session(-1, 0, 2, -1, 0);
        #3 pReset_n = 1'b1;
        step();
        chk("post_rst_idle", 64'(busy), 64'd0);
        chk("post_rst_wl", 64'(wl), 64'd0);
        session(-1, 0, -1, -1, 0);
        session(-1, 0, -1, 7, 0);
        session(-1, 0, -1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
